pc_sequencer: RTL and testbench



---
 rtl/risc8_pkg.sv | 30 +++
 rtl/fetch_timer.sv | 31 +++
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc8_pkg.sv
// Shared types for the 8-bit RISC core: sequencer states, branch codes,
// next-address mux select codes and the address width.
package risc8_pkg;

  localparam int ADDR_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALTED
  } state_e;

  typedef enum logic [1:0] {
    BR_SEQ  = 2'd0,
    BR_JMP  = 2'd1,
    BR_CALL = 2'd2,
    BR_RET  = 2'd3
  } br_type_e;

  typedef enum logic [1:0] {
    SEL_LR  = 2'd0,
    SEL_INC = 2'd1,
    SEL_EA  = 2'd2
  } sel_e;

endpackage

// File: rtl/fetch_timer.sv
// Fetch wait counter: synchronous clear, count enable, and a terminal-count
// flag raised during the TMO-th enabled cycle after a clear.
module fetch_timer #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TMO + 1);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = en && (cnt == W'(TMO - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Program-address sequencer: owns PC/LR, runs fetch/decode/exec, drives the
// next-address mux select. Optional interrupt entry under PCSEQ_IRQ_EN.
module pc_sequencer
  import risc8_pkg::*;
#(
  parameter addr_t RESET_VEC = 8'h00,
  parameter int    FETCH_TMO = 15
`ifdef PCSEQ_IRQ_EN
  , parameter addr_t IRQ_VEC = 8'hF0
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic [1:0]  br_type,
  input  logic        br_take,
  input  logic [7:0]  ea,
  input  logic        mem_ready,
`ifdef PCSEQ_IRQ_EN
  input  logic        irq,
  output logic        irq_ack,
`endif
  output logic [1:0]  mux_sel,
  output logic [7:0]  pc,
  output logic [7:0]  lr,
  output logic        fetch_req,
  output logic        ir_load,
  output logic        exec_en,
  output logic        busy,
  output logic        fetch_err
);

  state_e state_q, state_d;
  addr_t  pc_q, pc_d, lr_q, lr_d, pc_inc;
  logic   err_q, err_d;
  logic   tmr_clr, tmr_en, tmr_tc;
  sel_e   sel;

  fetch_timer #(.TMO(FETCH_TMO)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  assign pc_inc = pc_q + 8'd1;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    lr_d      = lr_q;
    err_d     = err_q;
    sel       = SEL_INC;
    fetch_req = 1'b0;
    ir_load   = 1'b0;
    exec_en   = 1'b0;
    tmr_clr   = 1'b1;
    tmr_en    = 1'b0;
`ifdef PCSEQ_IRQ_EN
    irq_ack   = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          pc_d    = RESET_VEC;
          err_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        fetch_req = 1'b1;
        tmr_en    = 1'b1;
        // A ready in the terminal cycle still wins over the timeout.
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (tmr_tc) begin
          err_d   = 1'b1;
          state_d = ST_HALTED;
        end else begin
          tmr_clr = 1'b0;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        exec_en = 1'b1;
        pc_d    = pc_inc;
        case (br_type_e'(br_type))
          BR_JMP, BR_CALL: begin
            if (br_take) begin
              sel  = SEL_EA;
              pc_d = ea;
              if (br_type_e'(br_type) == BR_CALL) lr_d = pc_inc;
            end
          end
          BR_RET: begin
            sel  = SEL_LR;
            pc_d = lr_q;
          end
          default: ;
        endcase
`ifdef PCSEQ_IRQ_EN
        // Interrupt entry saves the would-be next PC; halt takes priority.
        if (irq && !halt) begin
          lr_d    = pc_d;
          pc_d    = IRQ_VEC;
          sel     = SEL_EA;
          irq_ack = 1'b1;
        end
`endif
        state_d = halt ? ST_HALTED : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VEC;
      lr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      lr_q    <= lr_d;
      err_q   <= err_d;
    end
  end

  assign mux_sel   = sel;
  assign pc        = pc_q;
  assign lr        = lr_q;
  assign fetch_err = err_q;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

  localparam logic [7:0] RESET_VEC = 8'h00;
  localparam int         FETCH_TMO = 15;
  localparam logic [7:0] IRQ_VEC   = 8'hF0;

  logic       clk = 1'b0;
  logic       rst_n, start, halt, br_take, mem_ready;
  logic [1:0] br_type, mux_sel;
  logic [7:0] ea, pc, lr;
  logic       fetch_req, ir_load, exec_en, busy, fetch_err;
`ifdef PCSEQ_IRQ_EN
  logic       irq, irq_ack;
`endif

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_VEC (RESET_VEC),
    .FETCH_TMO (FETCH_TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .halt      (halt),
    .br_type   (br_type),
    .br_take   (br_take),
    .ea        (ea),
    .mem_ready (mem_ready),
`ifdef PCSEQ_IRQ_EN
    .irq       (irq),
    .irq_ack   (irq_ack),
`endif
    .mux_sel   (mux_sel),
    .pc        (pc),
    .lr        (lr),
    .fetch_req (fetch_req),
    .ir_load   (ir_load),
    .exec_en   (exec_en),
    .busy      (busy),
    .fetch_err (fetch_err)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: which step of the instruction cycle we are in, how
  // long the current fetch has waited, and the architectural registers.
  typedef enum int {M_IDLE, M_FETCH, M_DECODE, M_EXEC, M_HALTED} mphase_e;
  mphase_e    m_phase;
  int         m_wait;
  logic [7:0] m_pc, m_lr;
  logic       m_err;

  logic [1:0] exp_sel;
  logic       exp_req, exp_ld, exp_ex, exp_busy, exp_ack;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE;
    m_wait  = 0;
    m_pc    = RESET_VEC;
    m_lr    = 8'h00;
    m_err   = 1'b0;
  endtask

  function automatic logic irq_taken();
`ifdef PCSEQ_IRQ_EN
    return irq && !halt;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_exp();
    exp_req  = (m_phase == M_FETCH);
    exp_ld   = (m_phase == M_FETCH) && mem_ready;
    exp_ex   = (m_phase == M_EXEC);
    exp_busy = (m_phase != M_IDLE) && (m_phase != M_HALTED);
    exp_ack  = exp_ex && irq_taken();
    exp_sel  = 2'd1;
    if (exp_ex) begin
      if (exp_ack)                                    exp_sel = 2'd2;
      else if (br_type == 2'd3)                       exp_sel = 2'd0;
      else if ((br_type == 2'd1 || br_type == 2'd2) && br_take) exp_sel = 2'd2;
    end
  endtask

  task automatic model_next();
    logic [7:0] np, nl;
    case (m_phase)
      M_IDLE, M_HALTED: if (start) begin
        m_pc = RESET_VEC; m_err = 1'b0; m_phase = M_FETCH; m_wait = 0;
      end
      M_FETCH: begin
        m_wait++;
        if (mem_ready) begin
          m_phase = M_DECODE; m_wait = 0;
        end else if (m_wait == FETCH_TMO) begin
          m_err = 1'b1; m_phase = M_HALTED; m_wait = 0;
        end
      end
      M_DECODE: m_phase = M_EXEC;
      default: begin
        np = m_pc + 8'd1;
        nl = m_lr;
        if (br_type == 2'd1 && br_take) np = ea;
        if (br_type == 2'd2 && br_take) begin np = ea; nl = m_pc + 8'd1; end
        if (br_type == 2'd3) np = m_lr;
        if (irq_taken()) begin nl = np; np = IRQ_VEC; end
        m_pc = np; m_lr = nl;
        m_phase = halt ? M_HALTED : M_FETCH;
      end
    endcase
  endtask

  task automatic compare_all();
    check("mux_sel", mux_sel, exp_sel);
    check("pc", pc, m_pc);
    check("lr", lr, m_lr);
    check("fetch_req", fetch_req, exp_req);
    check("ir_load", ir_load, exp_ld);
    check("exec_en", exec_en, exp_ex);
    check("busy", busy, exp_busy);
    check("fetch_err", fetch_err, m_err);
`ifdef PCSEQ_IRQ_EN
    check("irq_ack", irq_ack, exp_ack);
`endif
  endtask

  // One clock: inputs already applied; compare at the falling edge.
  task automatic cycle();
    model_exp();
    @(negedge clk);
    compare_all();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; halt = 0; br_type = 0; br_take = 0; ea = 0; mem_ready = 0;
`ifdef PCSEQ_IRQ_EN
    irq = 0;
`endif
  endtask

  task automatic do_start();
    start = 1; cycle(); start = 0;
  endtask

  // Fetch with `waits` stall cycles, decode, then execute the given branch.
  task automatic do_instr(input logic [1:0] bt, input logic tk, input logic [7:0] e,
                          input logic h, input int waits, input logic [1:0] sel_lit);
    mem_ready = 0;
    repeat (waits) cycle();
    mem_ready = 1; cycle();
    mem_ready = 0; cycle();
    br_type = bt; br_take = tk; ea = e; halt = h;
    #0;
    check("lit_exec_en", exec_en, 1'b1);
    check("lit_mux_sel", mux_sel, sel_lit);
    cycle();
    br_type = 0; br_take = 0; ea = 0; halt = 0;
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    model_reset();
    #3;
    check("rst_pc", pc, 8'h00);
    check("rst_lr", lr, 8'h00);
    check("rst_mux_sel", mux_sel, 2'd1);
    check("rst_busy", busy, 1'b0);
    check("rst_fetch_req", fetch_req, 1'b0);
    check("rst_fetch_err", fetch_err, 1'b0);
    #9 rst_n = 1;
    @(posedge clk); #1;
    cycle(); cycle();

    // Sequential run at zero wait: 3 cycles per instruction.
    do_start();
    do_instr(2'd0, 0, 8'h00, 0, 0, 2'd1); check("seq_pc1", pc, 8'h01);
    do_instr(2'd0, 0, 8'h00, 0, 0, 2'd1); check("seq_pc2", pc, 8'h02);
    do_instr(2'd0, 0, 8'h00, 0, 0, 2'd1); check("seq_pc3", pc, 8'h03);
    do_instr(2'd0, 0, 8'h00, 0, 0, 2'd1); check("seq_pc4", pc, 8'h04);

    // Call / return.
    do_instr(2'd1, 1, 8'h10, 0, 0, 2'd2); check("jmp_pc", pc, 8'h10);
    do_instr(2'd2, 1, 8'h40, 0, 1, 2'd2);
    check("call_pc", pc, 8'h40);
    check("call_lr", lr, 8'h11);
    do_instr(2'd3, 0, 8'h99, 0, 2, 2'd0);
    check("ret_pc", pc, 8'h11);
    check("ret_lr", lr, 8'h11);

    // Wrap-around at 8'hFF for an untaken jump and for a call.
    do_instr(2'd1, 1, 8'hFF, 0, 0, 2'd2);
    do_instr(2'd1, 0, 8'h80, 0, 0, 2'd1); check("wrap_pc", pc, 8'h00);
    do_instr(2'd1, 1, 8'hFF, 0, 0, 2'd2);
    do_instr(2'd2, 1, 8'h30, 0, 0, 2'd2); check("wrap_call_lr", lr, 8'h00);

    // Halt at pc 05: pc still advances, sequencer goes idle; start while busy ignored.
    do_instr(2'd1, 1, 8'h05, 0, 0, 2'd2);
    start = 1; cycle(); start = 0;
    do_instr(2'd0, 0, 8'h00, 1, 0, 2'd1);
    check("halt_pc", pc, 8'h06);
    check("halt_busy", busy, 1'b0);
    repeat (3) cycle();

    // Fetch timeout after FETCH_TMO stalled cycles, then restart clears it.
    do_start();
    mem_ready = 0;
    repeat (FETCH_TMO - 1) cycle();
    check("tmo_busy_before", busy, 1'b1);
    cycle();
    check("tmo_err", fetch_err, 1'b1);
    check("tmo_busy", busy, 1'b0);
    do_start();
    check("restart_err", fetch_err, 1'b0);
    check("restart_pc", pc, RESET_VEC);
    // Ready arriving in the last allowed cycle is a success.
    do_instr(2'd0, 0, 8'h00, 0, FETCH_TMO - 1, 2'd1);
    check("edge_pc", pc, 8'h01);
    check("edge_err", fetch_err, 1'b0);

    // Asynchronous reset in the middle of a fetch.
    do_instr(2'd1, 1, 8'h33, 0, 0, 2'd2);
    mem_ready = 0; cycle();
    rst_n = 0; #1;
    check("arst_pc", pc, 8'h00);
    check("arst_fetch_req", fetch_req, 1'b0);
    check("arst_busy", busy, 1'b0);
    model_reset(); model_exp(); compare_all();
    #2 rst_n = 1;
    cycle();

`ifdef PCSEQ_IRQ_EN
    do_start();
    do_instr(2'd1, 1, 8'h20, 0, 0, 2'd2);
    irq = 1;
    do_instr(2'd0, 0, 8'h00, 0, 0, 2'd2);
    irq = 0;
    check("irq_pc", pc, 8'hF0);
    check("irq_lr", lr, 8'h21);
    check("irq_ack_off", irq_ack, 1'b0);
    irq = 1;
    do_instr(2'd0, 0, 8'h00, 1, 0, 2'd1);
    irq = 0;
    check("irq_halt_pc", pc, 8'hF1);
    check("irq_halt_busy", busy, 1'b0);
`endif

    // Randomized traffic: readiness probability changes per segment.
    for (int seg = 0; seg < 16; seg++) begin
      int rdy_pct;
      case (seg % 4)
        0: rdy_pct = 100;
        1: rdy_pct = 60;
        2: rdy_pct = 25;
        default: rdy_pct = 3;
      endcase
      for (int i = 0; i < 200; i++) begin
        start     = ($urandom_range(0, 7) == 0);
        halt      = ($urandom_range(0, 15) == 0);
        br_type   = 2'($urandom_range(0, 3));
        br_take   = 1'($urandom_range(0, 1));
        ea        = 8'($urandom_range(0, 255));
        mem_ready = ($urandom_range(1, 100) <= rdy_pct);
`ifdef PCSEQ_IRQ_EN
        irq       = ($urandom_range(0, 7) == 0);
`endif
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
